// File: rtl/uart_pkg.sv
// Shared definitions for the UART word link: byte width, echo TX state
// encoding and a width helper for counters and pointers.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT,
    TX_BUSY
  } tx_state_t;

  // Bits needed to hold values 0..value-1; never less than 1 so that
  // degenerate parameters still give a legal vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    while ((64'(1) << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Small synchronous byte FIFO buffering echo bytes for uart_tx.
//   clk, rst_n : clock, async active-low reset (clears pointers)
//   push       : write push_data (accepted when not full, or when popping)
//   push_data  : byte to enqueue
//   pop        : remove head (ignored when empty)
//   head_c     : current head byte, combinational read of the storage
//   full/empty : registered occupancy flags
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_BYTE_W-1:0] head_c,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_nxt;
  logic                   do_push;
  logic                   do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head_c  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointers and flags; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_word_link.sv
// Collects DATA_BYTES bytes from uart_rx into a word offered on a
// valid/ready handshake, drops stale partial words after an inter-byte
// timeout, and optionally echoes received bytes to uart_tx.
//   rx_valid/rx_data     : byte strobe and data from uart_rx
//   word_data/word_valid : assembled word, held until word_ready
//   word_ready           : consumer accept
//   echo_en              : enable echo pushes
//   tx_busy              : uart_tx shifting
//   tx_wr_en/tx_data     : one-cycle write to uart_tx
//   byte_cnt             : bytes held in the current partial word
//   timeout_evt          : one-cycle pulse when a partial word is discarded
//   overflow/echo_drop   : sticky loss flags, cleared by status_clr
module uart_word_link
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = 2,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned ECHO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx_valid,
  input  logic [UART_BYTE_W-1:0]            rx_data,
  output logic [UART_BYTE_W*DATA_BYTES-1:0] word_data,
  output logic                              word_valid,
  input  logic                              word_ready,
  input  logic                              echo_en,
  input  logic                              tx_busy,
  output logic                              tx_wr_en,
  output logic [UART_BYTE_W-1:0]            tx_data,
  output logic [2:0]                        byte_cnt,
  output logic                              timeout_evt,
  output logic                              overflow,
  output logic                              echo_drop,
  input  logic                              status_clr
);

  localparam int unsigned WORD_W   = UART_BYTE_W * DATA_BYTES;
  localparam int unsigned TMO_W    = clog2(TIMEOUT_CYC);
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  logic [WORD_W-1:0]      acc;
  logic [WORD_W-1:0]      acc_nxt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   last_byte;
  logic                   word_done;
  logic                   xfer;
  logic                   tmo_fire;
  logic                   echo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_head;
  tx_state_t              tx_state;

  // Accumulator with the incoming byte placed in slot byte_cnt; slot 0 is
  // the word's top byte when MSB_FIRST, its bottom byte otherwise.
  always_comb begin
    acc_nxt = acc;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (byte_cnt == 3'(i)) begin
        if (MSB_FIRST != 0) begin
          acc_nxt[(DATA_BYTES-1-i)*UART_BYTE_W +: UART_BYTE_W] = rx_data;
        end else begin
          acc_nxt[i*UART_BYTE_W +: UART_BYTE_W] = rx_data;
        end
      end
    end
  end

  assign last_byte = (byte_cnt == 3'(DATA_BYTES - 1));
  assign word_done = rx_valid & last_byte;
  assign xfer      = word_valid & word_ready;
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_fire  = (TIMEOUT_CYC != 0) && !rx_valid && (byte_cnt != 3'd0) &&
                     (tmo_cnt == TMO_W'(TMO_LAST));

  // Byte collection and inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      byte_cnt    <= 3'd0;
      tmo_cnt     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= tmo_fire;
      if (rx_valid) begin
        acc      <= acc_nxt;
        byte_cnt <= last_byte ? 3'd0 : byte_cnt + 3'd1;
        tmo_cnt  <= '0;
      end else if (tmo_fire) begin
        byte_cnt <= 3'd0;
        tmo_cnt  <= '0;
      end else if (byte_cnt != 3'd0) begin
        tmo_cnt  <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Output word register; a completing word loads only when the register
  // is free or being emptied this cycle, otherwise it is counted as lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (word_done && (!word_valid || word_ready)) begin
        word_data  <= acc_nxt;
        word_valid <= 1'b1;
      end else if (xfer) begin
        word_valid <= 1'b0;
      end
      overflow <= (word_done & word_valid & ~word_ready) | (overflow & ~status_clr);
    end
  end

  assign echo_push = echo_en & rx_valid;
  assign fifo_pop  = (tx_state == TX_IDLE) & ~fifo_empty & ~tx_busy;

  uart_echo_fifo #(
    .DEPTH (ECHO_DEPTH)
  ) u_echo_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (echo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .head_c    (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Echo TX pacing; TX_WAIT covers the cycle before uart_tx raises tx_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_wr_en  <= 1'b0;
      tx_data   <= '0;
      echo_drop <= 1'b0;
    end else begin
      tx_wr_en  <= fifo_pop;
      if (fifo_pop) tx_data <= fifo_head;
      echo_drop <= (echo_push & fifo_full & ~fifo_pop) | (echo_drop & ~status_clr);
      case (tx_state)
        TX_IDLE: if (fifo_pop) tx_state <= TX_WAIT;
        TX_WAIT: tx_state <= TX_BUSY;
        TX_BUSY: if (!tx_busy) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_link.sv
// Directed/randomised bench for uart_word_link: a 2-byte MSB-first instance
// with a 100-cycle timeout and echo, plus a 4-byte LSB-first instance with
// the timeout disabled, both fed from the same byte stream.
module tb_uart_word_link;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        word_ready;
  logic        echo_en;
  logic        tx_busy;
  logic        status_clr;

  logic [15:0] w2_data;
  logic        w2_valid, w2_txw, w2_tmo, w2_ovf, w2_edrop;
  logic [7:0]  w2_txd;
  logic [2:0]  w2_cnt;

  logic [31:0] w4_data;
  logic        w4_valid, w4_txw, w4_tmo, w4_ovf, w4_edrop;
  logic [7:0]  w4_txd;
  logic [2:0]  w4_cnt;

  int          checks = 0;
  int          failures = 0;
  int          busy_cnt = 0;
  int          tmo2_pulses = 0;
  int          tmo4_pulses = 0;
  logic [7:0]  echo_q[$];
  logic [7:0]  sent[$];

  always #5 clk = ~clk;

  uart_word_link #(
    .DATA_BYTES(2), .MSB_FIRST(1), .TIMEOUT_CYC(100), .ECHO_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .word_data(w2_data), .word_valid(w2_valid), .word_ready(word_ready),
    .echo_en(echo_en), .tx_busy(tx_busy), .tx_wr_en(w2_txw), .tx_data(w2_txd),
    .byte_cnt(w2_cnt), .timeout_evt(w2_tmo), .overflow(w2_ovf),
    .echo_drop(w2_edrop), .status_clr(status_clr)
  );

  uart_word_link #(
    .DATA_BYTES(4), .MSB_FIRST(0), .TIMEOUT_CYC(0), .ECHO_DEPTH(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .word_data(w4_data), .word_valid(w4_valid), .word_ready(word_ready),
    .echo_en(1'b0), .tx_busy(1'b0), .tx_wr_en(w4_txw), .tx_data(w4_txd),
    .byte_cnt(w4_cnt), .timeout_evt(w4_tmo), .overflow(w4_ovf),
    .echo_drop(w4_edrop), .status_clr(status_clr)
  );

  // uart_tx stand-in: records each written byte and stays busy 50 cycles.
  always @(posedge clk) begin
    if (w2_txw) begin
      echo_q.push_back(w2_txd);
      busy_cnt <= 50;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (w2_tmo) tmo2_pulses <= tmo2_pulses + 1;
    if (w4_tmo) tmo4_pulses <= tmo4_pulses + 1;
  end
  assign tx_busy = (busy_cnt != 0);

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    sent.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Word formed by the last n bytes sent, by arithmetic on byte order.
  function automatic logic [63:0] last_word(input int n, input bit msb);
    logic [63:0] w;
    int          base;
    w    = '0;
    base = sent.size() - n;
    for (int i = 0; i < n; i++) begin
      if (msb) w = (w << 8) | 64'(sent[base + i]);
      else     w = w | (64'(sent[base + i]) << (8 * i));
    end
    return w;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_wdata"},  w2_data,  0);
    check({tag, "_wvalid"}, w2_valid, 0);
    check({tag, "_txwr"},   w2_txw,   0);
    check({tag, "_txdata"}, w2_txd,   0);
    check({tag, "_cnt"},    w2_cnt,   0);
    check({tag, "_tmo"},    w2_tmo,   0);
    check({tag, "_ovf"},    w2_ovf,   0);
    check({tag, "_edrop"},  w2_edrop, 0);
    check({tag, "_w4data"}, w4_data,  0);
    check({tag, "_w4cnt"},  w4_cnt,   0);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] ex[$];
    int         base;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    word_ready = 1'b1; echo_en = 1'b0; status_clr = 1'b0;
    idle(3);
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Basic 2-byte word, MSB first.
    send_byte(8'h12);
    check("t1_cnt1", w2_cnt, 1);
    check("t1_novalid", w2_valid, 0);
    send_byte(8'h34);
    check("t1_valid", w2_valid, 1);
    check("t1_data", w2_data, 16'h1234);
    check("t1_cnt0", w2_cnt, 0);
    tick();
    check("t1_consumed", w2_valid, 0);

    // 4-byte LSB-first word.
    reset_pulse();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check("t2_w4valid", w4_valid, 1);
    check("t2_w4data", w4_data, 32'hDDCCBBAA);
    check("t2_w2data", w2_data, 16'hCCDD);

    // Random bytes with random gaps under the timeout.
    for (int k = 0; k < 24; k++) begin
      idle($urandom_range(0, 20));
      send_byte(8'($urandom));
      if (k % 2 == 0) begin
        check("rnd_cnt", w2_cnt, 1);
      end else begin
        check("rnd_w2valid", w2_valid, 1);
        check("rnd_w2data", w2_data, last_word(2, 1));
      end
      if (k % 4 == 3) check("rnd_w4data", w4_data, last_word(4, 0));
    end

    // Timeout boundary: a byte in the expiry cycle is kept.
    reset_pulse();
    send_byte(8'($urandom));
    idle(99);
    send_byte(8'($urandom));
    check("tmo_edge_valid", w2_valid, 1);
    check("tmo_edge_data", w2_data, last_word(2, 1));
    check("tmo_edge_nopulse", tmo2_pulses, 0);
    send_byte(8'h55);
    idle(100);
    check("tmo_evt", w2_tmo, 1);
    check("tmo_cnt0", w2_cnt, 0);
    check("tmo_w4cnt", w4_cnt, 3);
    tick();
    check("tmo_evt_low", w2_tmo, 0);
    send_byte(8'h01);
    check("tmo_w4data", w4_data, last_word(4, 0));
    send_byte(8'h02);
    check("tmo_word", w2_data, 16'h0102);
    check("tmo_pulses", tmo2_pulses, 1);
    check("tmo_disabled", tmo4_pulses, 0);

    // Overflow, sticky clear, set-wins and load-during-transfer.
    reset_pulse();
    word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    check("ovf_keep", w2_data, 16'h1111);
    check("ovf_valid", w2_valid, 1);
    check("ovf_set", w2_ovf, 1);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    check("ovf_clr", w2_ovf, 0);
    check("ovf_keep2", w2_data, 16'h1111);
    send_byte(8'h33);
    status_clr = 1'b1;
    send_byte(8'h33);
    status_clr = 1'b0;
    check("ovf_setwins", w2_ovf, 1);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    check("ovf_clr2", w2_ovf, 0);
    send_byte(8'h44);
    word_ready = 1'b1;
    send_byte(8'h44);
    check("xfer_load_valid", w2_valid, 1);
    check("xfer_load_data", w2_data, 16'h4444);
    check("xfer_load_noovf", w2_ovf, 0);
    tick();
    check("xfer_drain", w2_valid, 0);

    // Echo burst of 6 into a 4-deep FIFO: 5 go out, the 6th is dropped.
    reset_pulse();
    ex.delete();
    base = echo_q.size();
    echo_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom);
      ex.push_back(r);
      send_byte(r);
    end
    echo_en = 1'b0;
    for (int i = 0; i < 800 && (echo_q.size() - base) < 5; i++) tick();
    idle(120);
    check("echo_count", echo_q.size() - base, 5);
    for (int i = 0; i < 5 && i < echo_q.size() - base; i++)
      check($sformatf("echo_byte%0d", i), echo_q[base + i], ex[i]);
    check("echo_drop", w2_edrop, 1);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    check("echo_drop_clr", w2_edrop, 0);

    // Disabling echo stops pushes but queued bytes still drain.
    ex.delete();
    base = echo_q.size();
    echo_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      ex.push_back(r);
      send_byte(r);
    end
    echo_en = 1'b0;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    for (int i = 0; i < 500 && (echo_q.size() - base) < 3; i++) tick();
    idle(120);
    check("drain_count", echo_q.size() - base, 3);
    for (int i = 0; i < 3 && i < echo_q.size() - base; i++)
      check($sformatf("drain_byte%0d", i), echo_q[base + i], ex[i]);
    check("drain_nodrop", w2_edrop, 0);

    // Asynchronous reset mid-word clears everything.
    reset_pulse();
    word_ready = 1'b0;
    send_byte(8'h5A); send_byte(8'hA5);
    send_byte(8'h3C); send_byte(8'hC3);
    send_byte(8'h77);
    check("pre_rst_ovf", w2_ovf, 1);
    check("pre_rst_cnt", w2_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    tick();
    rst_n = 1'b1;
    word_ready = 1'b1;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    check("post_rst_valid", w2_valid, 1);
    check("post_rst_data", w2_data, last_word(2, 1));
    check("post_rst_w4cnt", w4_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_link.md
Name: uart_word_link

Overview:
- Parametrised successor to the 2-byte UART word collector; sits between `uart_rx` and `uart_tx`.
- Assembles DATA_BYTES received bytes into one word and presents it to the consumer on a valid/ready handshake.
- Discards partial words after an inter-byte timeout and flags lost words.
- Optionally echoes every received byte back through a small FIFO that paces `uart_tx` by `tx_busy`.

Parameters:
- DATA_BYTES, 2, bytes per word (1..8); word width = 8*DATA_BYTES.
- MSB_FIRST, 1, 1: first received byte lands in word[MSB]; 0: first byte lands in word[7:0].
- TIMEOUT_CYC, 1000000, idle clocks allowed between bytes of one word; 0 disables timeout.
- ECHO_DEPTH, 4, echo FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle pulse from `uart_rx`: `rx_data` is valid
- rx_data  input  8  received byte
- word_data  output  8*DATA_BYTES  assembled word
- word_valid  output  1  `word_data` holds an unconsumed word
- word_ready  input  1  consumer accepts the word when high with `word_valid`
- echo_en  input  1  echo received bytes to TX
- tx_busy  input  1  `uart_tx` is shifting a byte
- tx_wr_en  output  1  one-cycle write pulse to `uart_tx`
- tx_data  output  8  byte for `uart_tx`, valid with `tx_wr_en`
- byte_cnt  output  3  bytes collected in the current partial word
- timeout_evt  output  1  one-cycle pulse: partial word discarded
- overflow  output  1  sticky: a complete word was dropped
- echo_drop  output  1  sticky: an echo byte was dropped, FIFO full
- status_clr  input  1  clears `overflow` and `echo_drop`

Behaviour:
- Reset (asynchronous, active-low, with `clk` as the only clock): all outputs go to 0; byte counter, timeout counter and echo FIFO pointers are cleared. Reset mid-word discards the partial word and any FIFO contents.
- Collection, per `rx_valid`:
  - The byte goes into shift register slot `byte_cnt`; `byte_cnt` increments.
  - On the DATA_BYTES-th byte, the complete word is transferred to the output register at the next edge (`word_valid` rises 1 cycle after the last `rx_valid`) and `byte_cnt` returns to 0 in the same edge.
  - MSB_FIRST=1 with bytes A then B gives `word_data`={A,B}; MSB_FIRST=0 gives {B,A}.
- Output handshake:
  - `word_valid` stays high and `word_data` stays stable until `word_ready`=1.
  - A transfer occurs on any cycle with `word_valid`&`word_ready`; `word_valid` falls next cycle unless a new word completes that same cycle.
  - If a word completes while the register is full and `word_ready`=0: the new word is dropped, the old word is kept, and `overflow` is set.
  - If a word completes in the same cycle as a transfer: the new word loads and `word_valid` stays 1, with no overflow.
- Timeout:
  - The counter reloads to 0 on every `rx_valid` and counts only while `byte_cnt`!=0.
  - When it reaches TIMEOUT_CYC-1 with no `rx_valid` in that cycle: `byte_cnt` becomes 0 and `timeout_evt` pulses for 1 cycle.
  - If `rx_valid` coincides with the expiry cycle, the byte is appended and no timeout occurs.
  - TIMEOUT_CYC=0 means the timeout never fires.
- Echo:
  - When `echo_en`=1 and `rx_valid`=1, `rx_data` is pushed into the FIFO.
  - If the FIFO is full, the byte is not pushed and `echo_drop` is set. Collection is unaffected either way.
  - TX FSM states:
    - TX_IDLE: FIFO non-empty and `tx_busy`=0 -> pop, `tx_wr_en`=1 for 1 cycle with `tx_data`=head -> TX_WAIT.
    - TX_WAIT: hold 1 cycle to cover `uart_tx` busy latency -> TX_BUSY.
    - TX_BUSY: `tx_busy`=0 -> TX_IDLE.
  - Push and pop in the same cycle on a full FIFO is allowed: the pop frees a slot, so there is no drop.
  - Deasserting `echo_en` stops pushes only; queued bytes still drain.
- Status: `status_clr` clears the sticky bits. If a set event coincides with a clear, set wins.

Decomposition:
- Package `uart_pkg`:
  - UART_BYTE_W=8.
  - typedef enum `tx_state_t` {TX_IDLE, TX_WAIT, TX_BUSY}.
  - Function `clog2` for pointer and counter widths.
- Sub-module `uart_echo_fifo`: synchronous FIFO, parameters DEPTH and width 8; push/pop/full/empty.
- All collection, timeout and handshake logic stays in `uart_word_link`.

Test Plan:
- DATA_BYTES=2, MSB_FIRST=1, `word_ready`=1; rx 0x12 then 0x34 -> `word_valid` 1 cycle after 2nd `rx_valid`, `word_data`=0x1234, `byte_cnt` 0.
- DATA_BYTES=4, MSB_FIRST=0; rx 0xAA,0xBB,0xCC,0xDD -> `word_data`=0xDDCCBBAA.
- TIMEOUT_CYC=100; rx 0x55, idle 100 clocks, rx 0x01,0x02 -> `timeout_evt` pulses once, `word_data`=0x0102.
- `word_ready`=0; send words 0x1111 then 0x2222 -> `word_data` stays 0x1111 and `overflow`=1; `status_clr` -> `overflow`=0.
- `echo_en`=1, ECHO_DEPTH=4, `tx_busy` high 50 cycles after each write; burst 6 bytes -> first 5 echoed in order, 6th dropped, `echo_drop`=1.
- Assert `rst_n`=0 after 1 byte of a 2-byte word -> all outputs 0; next 2 bytes form a correct word.
